// File: rtl/spi_frame_ctrl.sv
// SPI-style frame sequencer: frames cs_n, shifts a command out MSB-first, skips
// the converter busy period(s), shifts a result word in and reports it with done.
module spi_frame_ctrl #(
    parameter int CMD_W    = 8,
    parameter int GAP_BITS = 1,
    parameter int DATA_W   = 12,
    parameter int PAD_BITS = 3,
    parameter int HOLD_CYC = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [CMD_W-1:0]  cmd,
    input  logic              write,
    input  logic              read,
    input  logic              miso,
    output logic              cs_n,
    output logic              mosi,
    output logic              sclk_gate,
    output logic              busy,
    output logic              done,
    output logic [DATA_W-1:0] rx_data
);

    localparam int TOT = CMD_W + GAP_BITS + DATA_W + PAD_BITS;
    localparam int KW  = $clog2(TOT + 1);
    localparam int HW  = $clog2(HOLD_CYC + 1);

    localparam logic [KW-1:0] K_LAST    = KW'(TOT - 1);
    localparam logic [KW-1:0] K_CMD_END = KW'(CMD_W);
    localparam logic [KW-1:0] K_DATA_LO = KW'(CMD_W + GAP_BITS);
    localparam logic [KW-1:0] K_DATA_HI = KW'(CMD_W + GAP_BITS + DATA_W);
    localparam logic [HW-1:0] H_LAST    = HW'(HOLD_CYC - 1);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_SETUP = 3'd1;
    localparam logic [2:0] S_SHIFT = 3'd2;
    localparam logic [2:0] S_HOLD  = 3'd3;
    localparam logic [2:0] S_FIN   = 3'd4;

    logic [2:0]        state;
    logic [KW-1:0]     k;
    logic [HW-1:0]     hold_cnt;
    logic [CMD_W-1:0]  tx_sr;
    logic [DATA_W-1:0] rx_sr;
    logic              wr_ok;

    logic              rd_last;
    logic              rd_adv;
    logic [KW-1:0]     k_new;
    logic              wr_take;

    // A read closes the current period before a same-cycle write is applied, and a
    // write is only accepted once the read of the previous period has been seen.
    always_comb begin
        rd_last = read && (k == K_LAST);
        rd_adv  = read && !rd_last;
        k_new   = rd_adv ? k + KW'(1) : k;
        wr_take = write && (wr_ok || rd_adv);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= S_IDLE;
            k         <= '0;
            hold_cnt  <= '0;
            tx_sr     <= '0;
            rx_sr     <= '0;
            wr_ok     <= 1'b0;
            cs_n      <= 1'b1;
            mosi      <= 1'b0;
            sclk_gate <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            rx_data   <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        tx_sr     <= cmd;
                        rx_sr     <= '0;
                        k         <= '0;
                        wr_ok     <= 1'b0;
                        cs_n      <= 1'b0;
                        busy      <= 1'b1;
                        sclk_gate <= 1'b0;
                        mosi      <= 1'b0;
                        state     <= S_SETUP;
                    end
                end
                S_SETUP: begin
                    if (write) begin
                        k         <= '0;
                        mosi      <= tx_sr[CMD_W-1];
                        tx_sr     <= {tx_sr[CMD_W-2:0], 1'b0};
                        sclk_gate <= 1'b1;
                        wr_ok     <= 1'b0;
                        state     <= S_SHIFT;
                    end
                end
                S_SHIFT: begin
                    if (read && (k >= K_DATA_LO) && (k < K_DATA_HI)) begin
                        rx_sr <= {rx_sr[DATA_W-2:0], miso};
                    end
                    if (rd_last) begin
                        sclk_gate <= 1'b0;
                        mosi      <= 1'b0;
                        hold_cnt  <= '0;
                        wr_ok     <= 1'b0;
                        state     <= S_HOLD;
                    end else begin
                        k <= k_new;
                        if (wr_take) begin
                            mosi  <= (k_new < K_CMD_END) ? tx_sr[CMD_W-1] : 1'b0;
                            tx_sr <= {tx_sr[CMD_W-2:0], 1'b0};
                            wr_ok <= 1'b0;
                        end else if (rd_adv) begin
                            wr_ok <= 1'b1;
                        end
                    end
                end
                S_HOLD: begin
                    if (hold_cnt == H_LAST) begin
                        cs_n    <= 1'b1;
                        done    <= 1'b1;
                        rx_data <= rx_sr;
                        state   <= S_FIN;
                    end else begin
                        hold_cnt <= hold_cnt + HW'(1);
                    end
                end
                S_FIN: begin
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_spi_frame_ctrl.sv
// Bench for spi_frame_ctrl: builds a strobe schedule per frame and predicts every
// output cycle from the frame timeline, plus literal checks on key results.
module tb_spi_frame_ctrl;

    localparam int CMD_W    = 8;
    localparam int GAP_BITS = 1;
    localparam int DATA_W   = 12;
    localparam int PAD_BITS = 3;
    localparam int HOLD_CYC = 4;
    localparam int TOT      = CMD_W + GAP_BITS + DATA_W + PAD_BITS;

    logic              clk = 1'b0;
    logic              reset;
    logic              start;
    logic [CMD_W-1:0]  cmd;
    logic              write;
    logic              read;
    logic              miso;
    logic              cs_n;
    logic              mosi;
    logic              sclk_gate;
    logic              busy;
    logic              done;
    logic [DATA_W-1:0] rx_data;

    always #5 clk = ~clk;

    spi_frame_ctrl #(
        .CMD_W(CMD_W), .GAP_BITS(GAP_BITS), .DATA_W(DATA_W),
        .PAD_BITS(PAD_BITS), .HOLD_CYC(HOLD_CYC)
    ) dut (
        .clk(clk), .reset(reset), .start(start), .cmd(cmd),
        .write(write), .read(read), .miso(miso),
        .cs_n(cs_n), .mosi(mosi), .sclk_gate(sclk_gate),
        .busy(busy), .done(done), .rx_data(rx_data)
    );

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    logic              chk_en = 1'b0;
    logic              exp_cs_n, exp_mosi, exp_gate, exp_busy, exp_done;
    logic [DATA_W-1:0] exp_rx;
    logic [DATA_W-1:0] model_rx;

    logic              mon_clr = 1'b1;
    int                gate_reads;
    int                done_cnt;
    logic [TOT-1:0]    mosi_cap;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s at cycle %0d: got %h, expected %h", name, cyc, act, exp);
        end
    endtask

    // Per-cycle comparison against the timeline prediction.
    always @(negedge clk) begin
        if (chk_en) begin
            checkOutput("cs_n", 32'(cs_n), 32'(exp_cs_n));
            checkOutput("mosi", 32'(mosi), 32'(exp_mosi));
            checkOutput("sclk_gate", 32'(sclk_gate), 32'(exp_gate));
            checkOutput("busy", 32'(busy), 32'(exp_busy));
            checkOutput("done", 32'(done), 32'(exp_done));
            checkOutput("rx_data", 32'(rx_data), 32'(exp_rx));
        end
    end

    // Independent observer: what the device would see on the wire.
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (mon_clr) begin
            gate_reads <= 0;
            done_cnt   <= 0;
            mosi_cap   <= '0;
        end else begin
            if (read && sclk_gate) begin
                if (gate_reads < TOT) mosi_cap[TOT-1-gate_reads] <= mosi;
                gate_reads <= gate_reads + 1;
            end
            if (done) done_cnt <= done_cnt + 1;
        end
    end

    function automatic logic [TOT-1:0] make_frame(input logic [DATA_W-1:0] w, input logic g,
                                                  input logic [PAD_BITS-1:0] pd,
                                                  input logic [CMD_W-1:0] junk);
        return {junk, {GAP_BITS{g}}, w, pd};
    endfunction

    task automatic set_idle_exp(input logic [DATA_W-1:0] rx);
        exp_cs_n = 1'b1;
        exp_mosi = 1'b0;
        exp_gate = 1'b0;
        exp_busy = 1'b0;
        exp_done = 1'b0;
        exp_rx   = rx;
    endtask

    // One frame: period p has its write at wcyc[p] and its read at rcyc[p]
    // (cycle 0 is the cycle start is driven). dev holds miso for period p at bit TOT-1-p.
    task automatic applyStimulus(input logic [CMD_W-1:0] f_cmd, input logic [TOT-1:0] dev,
                                 input int h, input bit coinc, input int d,
                                 input int busy_p, input int rst_p, input bit fin_start);
        int wcyc[TOT+1];
        int rcyc[TOT];
        int last_rd, fin_c, end_c, rst_c, np, mp;
        logic [DATA_W-1:0] word;
        logic wr_s, rd_s;
        word    = dev[PAD_BITS +: DATA_W];
        wcyc[0] = 1 + d;
        for (int p = 0; p < TOT; p++) begin
            rcyc[p]   = wcyc[p] + h;
            wcyc[p+1] = coinc ? rcyc[p] : rcyc[p] + h;
        end
        last_rd = rcyc[TOT-1];
        fin_c   = last_rd + HOLD_CYC + 1;
        rst_c   = (rst_p >= 0) ? wcyc[rst_p] + 1 : -1;
        end_c   = (rst_c >= 0) ? rst_c + 2 : fin_c + 2;
        for (int c = 0; c <= end_c; c++) begin
            @(posedge clk); #1;
            mon_clr = (c == 0);
            wr_s = 1'b0;
            rd_s = 1'b0;
            np = 0;
            mp = -1;
            for (int p = 0; p <= TOT; p++) begin
                if (wcyc[p] == c) wr_s = 1'b1;
                if (p < TOT) begin
                    if (wcyc[p] < c) mp = p;
                    if (rcyc[p] == c) rd_s = 1'b1;
                    if (rcyc[p] < c) np++;
                end
            end
            if (d >= 1 && c == 1) rd_s = 1'b1;
            if (!coinc && h >= 2) begin
                for (int p = 1; p < TOT; p += 2) if (c == wcyc[p] + 1) wr_s = 1'b1;
            end
            write = wr_s;
            read  = rd_s;
            miso  = (np < TOT) ? dev[TOT-1-np] : 1'($urandom);
            start = 1'b0;
            cmd   = CMD_W'($urandom);
            if (c == 0) begin
                start = 1'b1;
                cmd   = f_cmd;
            end else if (busy_p >= 0 && c == wcyc[busy_p] + 1) begin
                start = 1'b1;
                cmd   = '1;
            end else if (fin_start && c == fin_c) begin
                start = 1'b1;
            end
            reset = (c == rst_c);
            if (rst_c >= 0 && c >= rst_c) begin
                model_rx = '0;
                set_idle_exp(model_rx);
            end else if (c == 0) begin
                set_idle_exp(model_rx);
            end else begin
                exp_busy = (c <= fin_c);
                exp_cs_n = (c >= fin_c);
                exp_done = (c == fin_c);
                exp_gate = (c > wcyc[0]) && (c <= last_rd);
                exp_mosi = (exp_gate && mp >= 0 && mp < CMD_W) ? f_cmd[CMD_W-1-mp] : 1'b0;
                if (c == fin_c) model_rx = word;
                exp_rx = model_rx;
            end
        end
    endtask

    initial begin
        reset    = 1'b1;
        start    = 1'b0;
        cmd      = '0;
        write    = 1'b0;
        read     = 1'b0;
        miso     = 1'b0;
        model_rx = '0;
        set_idle_exp('0);
        chk_en   = 1'b1;

        // Reset held while strobes and start toggle.
        for (int i = 0; i < 8; i++) begin
            @(posedge clk); #1;
            write = 1'($urandom);
            read  = 1'($urandom);
            miso  = 1'($urandom);
            start = 1'($urandom);
            cmd   = CMD_W'($urandom);
        end
        @(posedge clk); #1;
        reset = 1'b0;
        start = 1'b0;
        write = 1'b0;
        read  = 1'b0;

        $display("[TB] directed frame cmd=0x93 data=0xA5C with ignored restart");
        applyStimulus(8'h93, make_frame(12'hA5C, 1'b0, 3'b000, 8'h00), 2, 1'b0, 2, 5, -1, 1'b1);
        checkOutput("frame1_mosi_bits", 32'(mosi_cap), 32'({8'h93, 16'h0000}));
        checkOutput("frame1_gated_reads", 32'(gate_reads), 32'd24);
        checkOutput("frame1_done_count", 32'(done_cnt), 32'd1);
        checkOutput("frame1_rx", 32'(rx_data), 32'h0A5C);

        $display("[TB] reset asserted mid-frame at period 12");
        applyStimulus(8'h93, make_frame(12'h3C7, 1'b0, 3'b000, 8'h00), 2, 1'b0, 1, -1, 12, 1'b0);
        checkOutput("abort_done_count", 32'(done_cnt), 32'd0);
        checkOutput("abort_rx", 32'(rx_data), 32'h0000);

        $display("[TB] frame cmd=0xD0 data=0xFFF after abort");
        applyStimulus(8'hD0, make_frame(12'hFFF, 1'b0, 3'b000, 8'h00), 1, 1'b0, 0, -1, -1, 1'b0);
        checkOutput("d0_rx", 32'(rx_data), 32'h0FFF);
        checkOutput("d0_mosi_bits", 32'(mosi_cap), 32'({8'hD0, 16'h0000}));

        $display("[TB] busy bit and pad periods driven high");
        applyStimulus(8'h5A, make_frame(12'h000, 1'b1, 3'b111, 8'h00), 3, 1'b0, 3, -1, -1, 1'b0);
        checkOutput("gap_pad_rx", 32'(rx_data), 32'h0000);
        checkOutput("gap_pad_done_count", 32'(done_cnt), 32'd1);

        $display("[TB] coincident read/write strobes, data=0x555");
        applyStimulus(8'h3C, make_frame(12'h555, 1'b0, 3'b000, 8'h00), 2, 1'b1, 1, -1, -1, 1'b0);
        checkOutput("coinc_rx", 32'(rx_data), 32'h0555);
        checkOutput("coinc_mosi_bits", 32'(mosi_cap), 32'({8'h3C, 16'h0000}));
        checkOutput("coinc_gated_reads", 32'(gate_reads), 32'd24);

        $display("[TB] randomized frames");
        for (int i = 0; i < 6; i++) begin
            applyStimulus(CMD_W'($urandom), TOT'($urandom), $urandom_range(1, 3),
                          1'($urandom), $urandom_range(0, 3),
                          ($urandom_range(0, 1) == 1) ? $urandom_range(0, TOT - 1) : -1,
                          -1, 1'($urandom));
        end

        @(posedge clk); #1;
        chk_en = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
